// File: rtl/octree_pkg.sv
// rtl/octree_pkg.sv - shared widths, ROM depth and response pipeline type for the octree fetch path
package octree_pkg;

    localparam int OCT_ADDR_W    = 32;
    localparam int OCT_DATA_W    = 32;
    localparam int OCT_ROM_DEPTH = 38;
    localparam int OCT_ID_W      = 3;

    // One response in flight: who asked, and whether the address missed the ROM
    typedef struct packed {
        logic                valid;
        logic [OCT_ID_W-1:0] id;
        logic                err;
    } oct_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    function automatic int wrap_idx(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    logic [IDX_W-1:0] idx [N];

    // Candidate order: ptr, ptr+1, ... wrapping modulo N
    always_comb begin
        for (int k = 0; k < N; k++) begin
            idx[k] = IDX_W'(wrap_idx(int'(ptr) + k));
        end
    end

    // First requester found in candidate order wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[idx[k]]) begin
                any          = 1'b1;
                gnt[idx[k]]  = 1'b1;
                gnt_idx      = idx[k];
            end
        end
    end

endmodule

// File: rtl/octree_fetch_arbiter.sv
// rtl/octree_fetch_arbiter.sv - round-robin sharing of the octree node ROM read port
module octree_fetch_arbiter
    import octree_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int ADDRESS_WIDTH = OCT_ADDR_W,
    parameter int DATA_WIDTH    = OCT_DATA_W,
    parameter int ROM_DEPTH     = OCT_ROM_DEPTH,
    localparam int ID_W         = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic [ADDRESS_WIDTH-1:0]       rom_addr,
    output logic                           rom_ren,
    input  logic [DATA_WIDTH-1:0]          rom_dout
);

    logic [ID_W-1:0]          rr_ptr;
    logic [N_REQ-1:0]         arb_gnt;
    logic [ID_W-1:0]          gnt_idx;
    logic                     arb_any;
    logic                     grant;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic                     in_range;
    oct_rsp_t                 p;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx),
        .any     (arb_any)
    );

    // Grant decode and ROM drive; nothing is granted while reset is held
    always_comb begin
        grant     = arb_any & ~rst;
        req_ready = rst ? '0 : arb_gnt;
        sel_addr  = req_addr[int'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        in_range  = sel_addr < ADDRESS_WIDTH'(ROM_DEPTH);
        rom_ren   = grant & in_range;
        rom_addr  = rom_ren ? sel_addr : '0;
    end

    // Pointer advance past the winner and one-stage response tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            p      <= '0;
        end else begin
            if (grant) begin
                rr_ptr <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
            end
            p.valid <= grant;
            p.id    <= grant ? OCT_ID_W'(gnt_idx) : '0;
            p.err   <= grant & ~in_range;
        end
    end

    // Response is formed from the tag and the ROM's registered output; an in-flight read is dropped under reset
    always_comb begin
        rsp_valid = (p.valid && !rst) ? (N_REQ'(1) << p.id[ID_W-1:0]) : '0;
        rsp_id    = rst ? '0 : p.id[ID_W-1:0];
        rsp_err   = p.err & ~rst;
        rsp_data  = (p.valid && !p.err && !rst) ? rom_dout : '0;
    end

endmodule
